// File: rtl/robot_nav.sv
`default_nettype none
// ============================================================================
//  Module   : robot_nav
//  Purpose  : Waypoint navigator for the robot position tracker. Accepts a
//             target (x, y) over valid/ready and steps the robot one cell per
//             cycle, first along X, then along Y. It flags arrival,
//             out-of-bounds targets and stalled motion.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        : clock, rising-edge active
//    rst_ni       : asynchronous active-low reset
//    tgt_x_i/y_i  : target coordinates, sampled on accept
//    tgt_valid_i  : target offered
//    tgt_ready_o  : navigator can accept a target (IDLE, DONE, ERR)
//    x_i / y_i    : current robot position (registered inside the robot)
//    direction_o  : step direction N=0, E=1, S=2, W=3 (N whenever move_o=0)
//    move_o       : step request to the robot
//    busy_o       : high while moving along X or Y
//    arrived_o    : one-cycle pulse on the first DONE cycle
//    error_o      : out-of-bounds or stall; held until next accept
//    steps_o      : steps issued for the current target, saturating
// ============================================================================
module robot_nav #(
    parameter int WIDTH       = 5,
    parameter int BOUND_X     = 10,
    parameter int BOUND_Y     = 10,
    parameter int STALL_LIMIT = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] tgt_x_i,
    input  logic [WIDTH-1:0] tgt_y_i,
    input  logic             tgt_valid_i,
    output logic             tgt_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [1:0]       direction_o,
    output logic             move_o,
    output logic             busy_o,
    output logic             arrived_o,
    output logic             error_o,
    output logic [WIDTH:0]   steps_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOVE_X = 3'd1,
        S_MOVE_Y = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] C_DIR_N = 2'd0;
    localparam logic [1:0] C_DIR_E = 2'd1;
    localparam logic [1:0] C_DIR_S = 2'd2;
    localparam logic [1:0] C_DIR_W = 2'd3;

    // Bounds compared one bit wider so a bound of 2^WIDTH still works.
    localparam logic [WIDTH:0] C_BOUND_X   = (WIDTH+1)'(BOUND_X);
    localparam logic [WIDTH:0] C_BOUND_Y   = (WIDTH+1)'(BOUND_Y);
    localparam logic [WIDTH:0] C_STEPS_MAX = '1;

    localparam int                   C_STALL_W    = $clog2(STALL_LIMIT + 1);
    // The counter reaches the limit on the cycle it would step from LIMIT-1.
    localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(STALL_LIMIT - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     tx_q, tx_d;
    logic [WIDTH-1:0]     ty_q, ty_d;
    logic [WIDTH:0]       steps_q, steps_d;
    logic [C_STALL_W-1:0] stall_q, stall_d;
    logic                 error_q, error_d;
    logic                 arrived_q, arrived_d;
    logic                 prev_move_q;
    logic [WIDTH-1:0]     prev_x_q, prev_y_q;

    logic w_accept;
    logic w_oob;
    logic w_stall_hit;

    assign tgt_ready_o = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign busy_o      = (state_q == S_MOVE_X) || (state_q == S_MOVE_Y);
    assign arrived_o   = arrived_q;
    assign error_o     = error_q;
    assign steps_o     = steps_q;

    assign w_accept    = tgt_valid_i && tgt_ready_o;
    assign w_oob       = ({1'b0, tgt_x_i} >= C_BOUND_X) || ({1'b0, tgt_y_i} >= C_BOUND_Y);
    // A step was commanded last cycle but the robot position did not change.
    assign w_stall_hit = prev_move_q && (x_i == prev_x_q) && (y_i == prev_y_q);

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        steps_d     = steps_q;
        stall_d     = stall_q;
        error_d     = error_q;
        arrived_d   = 1'b0;
        move_o      = 1'b0;
        direction_o = C_DIR_N;

        case (state_q)
            S_MOVE_X: begin
                stall_d = w_stall_hit ? stall_q + 1'b1 : '0;
                if (w_stall_hit && (stall_q == C_STALL_LAST)) begin
                    // Stall limit reached: suppress this step and abort.
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else if (x_i < tx_q) begin
                    move_o      = 1'b1;
                    direction_o = C_DIR_E;
                end else if (x_i > tx_q) begin
                    move_o      = 1'b1;
                    direction_o = C_DIR_W;
                end else begin
                    state_d = S_MOVE_Y;
                end
            end
            S_MOVE_Y: begin
                stall_d = w_stall_hit ? stall_q + 1'b1 : '0;
                if (w_stall_hit && (stall_q == C_STALL_LAST)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else if (y_i < ty_q) begin
                    move_o      = 1'b1;
                    direction_o = C_DIR_N;
                end else if (y_i > ty_q) begin
                    move_o      = 1'b1;
                    direction_o = C_DIR_S;
                end else begin
                    state_d   = S_DONE;
                    arrived_d = 1'b1;
                end
            end
            default: begin
                // IDLE, DONE and ERR all wait for the next target.
                if (w_accept) begin
                    tx_d    = tgt_x_i;
                    ty_d    = tgt_y_i;
                    steps_d = '0;
                    stall_d = '0;
                    if (w_oob) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_MOVE_X;
                        error_d = 1'b0;
                    end
                end
            end
        endcase

        if (move_o && (steps_q != C_STEPS_MAX)) begin
            steps_d = steps_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            tx_q        <= '0;
            ty_q        <= '0;
            steps_q     <= '0;
            stall_q     <= '0;
            error_q     <= 1'b0;
            arrived_q   <= 1'b0;
            prev_move_q <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            steps_q     <= steps_d;
            stall_q     <= stall_d;
            error_q     <= error_d;
            arrived_q   <= arrived_d;
            prev_move_q <= move_o;
            prev_x_q    <= x_i;
            prev_y_q    <= y_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_robot_nav.sv
`default_nettype none
// ============================================================================
//  Module   : tb_robot_nav
//  Purpose  : Self-checking bench for robot_nav. A simple robot model closes
//             the position loop; expected outcomes (arrival or error, cycle,
//             step count, final position) are computed from the target and
//             the robot position at accept, queued, and checked by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_robot_nav;
    localparam int WIDTH       = 5;
    localparam int BOUND_X     = 10;
    localparam int BOUND_Y     = 10;
    localparam int STALL_LIMIT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] tgt_x = '0;
    logic [WIDTH-1:0] tgt_y = '0;
    logic             tgt_valid = 1'b0;
    logic             tgt_ready;
    logic [1:0]       direction;
    logic             move, busy, arrived, error;
    logic [WIDTH:0]   steps;

    logic [WIDTH-1:0] rx = '0;
    logic [WIDTH-1:0] ry = '0;
    logic [WIDTH-1:0] set_x = '0;
    logic [WIDTH-1:0] set_y = '0;
    bit               set_req = 1'b0;
    bit               frozen  = 1'b0;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit is_err;
        int cyc;
        int steps;
        int fx;
        int fy;
    } exp_t;
    exp_t exp_q[$];

    robot_nav #(
        .WIDTH(WIDTH), .BOUND_X(BOUND_X), .BOUND_Y(BOUND_Y), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tgt_x_i(tgt_x), .tgt_y_i(tgt_y), .tgt_valid_i(tgt_valid), .tgt_ready_o(tgt_ready),
        .x_i(rx), .y_i(ry),
        .direction_o(direction), .move_o(move), .busy_o(busy),
        .arrived_o(arrived), .error_o(error), .steps_o(steps)
    );

    always #5 clk = ~clk;

    // Robot: moves one cell per move strobe unless frozen; bench may teleport it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (set_req) begin
            rx <= set_x;
            ry <= set_y;
        end else if (move && !frozen) begin
            case (direction)
                2'd0:    ry <= ry + 1'b1;
                2'd1:    rx <= rx + 1'b1;
                2'd2:    ry <= ry - 1'b1;
                default: rx <= rx - 1'b1;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   ev_arr, ev_err, err_prev, acc_prev, in_err, clr_chk, acc;
    int   mv_cnt;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mv_cnt   = 0;
            err_prev = 1'b0;
            acc_prev = 1'b0;
            in_err   = 1'b0;
            clr_chk  = 1'b0;
        end else begin
            ev_arr = arrived;
            // error is a level: a fresh event is a rising edge or a re-raise right after accept
            ev_err = error && (!err_prev || acc_prev);
            if (in_err) chk("move_in_err", int'(move), 0);
            if (clr_chk) begin
                chk("error_cleared", int'(error), 0);
                chk("arrived_low_after_accept", int'(arrived), 0);
            end
            if (ev_arr || ev_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_outcome", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("outcome_is_error", int'(ev_err), int'(mon_e.is_err));
                    chk("outcome_cycle", cyc, mon_e.cyc);
                    chk("steps", int'(steps), mon_e.steps);
                    chk("move_count", mv_cnt, mon_e.steps);
                    if (!mon_e.is_err) begin
                        chk("final_x", int'(rx), mon_e.fx);
                        chk("final_y", int'(ry), mon_e.fy);
                    end
                    in_err = ev_err;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                chk("outcome_timeout", cyc, exp_q[0].cyc);
                mon_e = exp_q.pop_front();
            end
            if (move) mv_cnt++;
            acc = tgt_valid && tgt_ready;
            clr_chk = 1'b0;
            if (acc) begin
                mv_cnt  = 0;
                in_err  = 1'b0;
                clr_chk = (int'(tgt_x) < BOUND_X) && (int'(tgt_y) < BOUND_Y);
            end
            err_prev = error;
            acc_prev = acc;
        end
    end

    // ---------------- driver ----------------
    task automatic send_target(input int tx, input int ty);
        int   budget;
        int   dx, dy;
        exp_t e;
        @(posedge clk);
        #1;
        tgt_x     = WIDTH'(tx);
        tgt_y     = WIDTH'(ty);
        tgt_valid = 1'b1;
        budget    = 300;
        @(negedge clk);
        while (!tgt_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!tgt_ready) begin
            chk("accept_timeout", 0, 1);
            tgt_valid = 1'b0;
            return;
        end
        // Accept happens at the coming edge; cyc+1 is the first cycle after it.
        dx = (tx > int'(rx)) ? tx - int'(rx) : int'(rx) - tx;
        dy = (ty > int'(ry)) ? ty - int'(ry) : int'(ry) - ty;
        if (tx >= BOUND_X || ty >= BOUND_Y)
            e = '{1'b1, cyc + 1, 0, 0, 0};
        else if (frozen && dx > 0)
            e = '{1'b1, cyc + 1 + STALL_LIMIT + 1, STALL_LIMIT, 0, 0};
        else
            e = '{1'b0, cyc + 1 + dx + dy + 2, dx + dy, tx, ty};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic set_pos(input int px, input int py);
        @(posedge clk);
        #1;
        set_x   = WIDTH'(px);
        set_y   = WIDTH'(py);
        set_req = 1'b1;
        @(posedge clk);
        #1;
        set_req = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 400;
        @(negedge clk);
        while (!(tgt_ready && exp_q.size() == 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!(tgt_ready && exp_q.size() == 0)) begin
            chk("idle_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;

        // Reset held with a target offered: nothing accepted, outputs at reset values.
        tgt_valid = 1'b1;
        tgt_x     = 5'd3;
        tgt_y     = 5'd3;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(tgt_ready), 1);
        chk("rst_move", int'(move), 0);
        chk("rst_direction", int'(direction), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_arrived", int'(arrived), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_steps", int'(steps), 0);
        tgt_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(tgt_ready), 1);
        chk("busy_after_release", int'(busy), 0);

        // Closed loop (0,0) -> (3,2).
        set_pos(0, 0);
        send_target(3, 2);
        wait_idle();

        // Out-of-bounds, then a legal target accepted straight from ERR.
        send_target(10, 4);
        send_target(1, 1);
        wait_idle();

        // Frozen robot feedback -> stall error.
        set_pos(2, 2);
        frozen = 1'b1;
        send_target(5, 2);
        wait_idle();
        frozen = 1'b0;

        // (4,4) -> (1,6) with the next target offered mid-move.
        set_pos(4, 4);
        send_target(1, 6);
        @(negedge clk);
        chk("ready_low_mid_move", int'(tgt_ready), 0);
        send_target(0, 0);
        wait_idle();

        // Reset during MOVE_Y, then target equal to current position.
        set_pos(0, 0);
        send_target(2, 5);
        budget = 100;
        @(negedge clk);
        while (!(move && direction == 2'd0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reached_move_y", int'(move && direction == 2'd0), 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_move", int'(move), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_steps", int'(steps), 0);
        chk("midreset_ready", int'(tgt_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_steps", int'(steps), 0);
        chk("post_reset_busy", int'(busy), 0);
        send_target(int'(rx), int'(ry));
        wait_idle();

        // Randomised targets, some out of bounds, with random gaps.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_target(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/robot_nav.md
# robot_nav

Waypoint navigator that drives the `robot` position tracker toward a commanded target. It accepts a target (x, y) over a valid/ready handshake and reads the robot's current `x`/`y` back as feedback. Each cycle it issues one `direction` plus a `move` step strobe: first along X, then along Y. It reports arrival, out-of-bounds targets and stalled motion (position not changing while commanded).

## Interface
- `WIDTH`, 5: coordinate width; matches the robot.
- `BOUND_X`, 10: legal x range is 0..BOUND_X-1.
- `BOUND_Y`, 10: legal y range is 0..BOUND_Y-1.
- `STALL_LIMIT`, 3: number of consecutive commanded steps with no position change that raises `error`.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `tgt_x  in  WIDTH`: target x; sampled on accept.
- `tgt_y  in  WIDTH`: target y; sampled on accept.
- `tgt_valid  in  1`: target offered.
- `tgt_ready  out  1`: navigator can accept a target.
- `x  in  WIDTH`: current robot x (registered in the robot).
- `y  in  WIDTH`: current robot y (registered in the robot).
- `direction  out  2`: step direction; encoding N=0, E=1, S=2, W=3.
- `move  out  1`: step request; the robot updates its position only when `move`=1.
- `busy  out  1`: high in the MOVE_X and MOVE_Y states.
- `arrived  out  1`: one-cycle pulse on reaching the target.
- `error  out  1`: level; held until the next accept or reset.
- `steps  out  WIDTH+1`: steps issued for the current target; saturating.

## Operation
- States: IDLE, MOVE_X, MOVE_Y, DONE, ERR.
- `tgt_ready` = 1 in IDLE, DONE and ERR; 0 in MOVE_X and MOVE_Y.
- Accept occurs on a clock edge with `tgt_valid` && `tgt_ready`. On accept:
  - latch `tgt_x` and `tgt_y`;
  - clear `steps`, the stall counter and `error`.
- Accept with `tgt_x` >= BOUND_X or `tgt_y` >= BOUND_Y: go to ERR and set `error`=1. Otherwise go to MOVE_X.
- MOVE_X:
  - x < tx: `direction`=E, `move`=1.
  - x > tx: `direction`=W, `move`=1.
  - x == tx: `move`=0; next state MOVE_Y.
- MOVE_Y:
  - y < ty: `direction`=N, `move`=1.
  - y > ty: `direction`=S, `move`=1.
  - y == ty: `move`=0; next state DONE, with `arrived`=1 for that first DONE cycle only.
- `direction` and `move` are combinational from state, the latched target and `x`/`y`. No loop exists, because `x`/`y` are registers in the robot.
- When `move`=0, `direction` holds N (0).
- `steps` increments on every cycle with `move`=1 and saturates at 2^(WIDTH+1)-1.
- Stall detection:
  - Register `prev_move`, `prev_x` and `prev_y` each cycle.
  - In MOVE_X or MOVE_Y, if `prev_move`=1 and x==prev_x and y==prev_y, the stall counter increments; otherwise it clears.
  - When the stall counter reaches STALL_LIMIT: go to ERR, set `error`=1, force `move`=0.
- DONE and ERR persist until the next accept. `tgt_valid` offered during MOVE_X/MOVE_Y is not accepted; the target stays pending at the source.
- All arithmetic is unsigned WIDTH-bit. Comparisons use the latched target only.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state = IDLE;
  - `tgt_ready`=1, `move`=0, `direction`=0, `busy`=0, `arrived`=0, `error`=0, `steps`=0;
  - latched target = 0, stall counter = 0, `prev_move`=0.
- Reset asserted mid-move: `move` drops immediately (asynchronous), and the in-flight target is discarded.
- Accept at edge k: state MOVE_X during cycle k+1; the first `move` can assert in cycle k+1.
- Each `move`=1 cycle produces a robot position change visible in the following cycle. Throughput is one step per cycle.
- The MOVE_X to MOVE_Y transition costs one idle cycle (`move`=0). The MOVE_Y to DONE transition costs one idle cycle.
- Distance (dx, dy): `arrived` pulses in cycle k+dx+dy+3, and `steps`=dx+dy.
- Target equal to the current position: `arrived` in cycle k+3, with `steps`=0.
- Out-of-bounds target: `error`=1 from cycle k+1, and `move` never asserts.
- Stall: `error` asserts in the cycle after the STALL_LIMIT-th consecutive unchanged commanded step.
- Accept in DONE or ERR at edge k: `error` clears and `arrived` stays 0 from cycle k+1.

## Test plan
- Reset: hold `rst`=0 with `tgt_valid`=1 -> all outputs at reset values, no accept; release -> `tgt_ready`=1.
- Closed loop with the robot from (0,0), target (3,2) -> E,E,E, one idle cycle, N,N, one idle cycle; `arrived` at accept+8; `steps`=5; final x=3, y=2.
- Target (10,4) -> ERR, `error`=1 at accept+1, `move` stays 0. A new target (1,1) is then accepted, and `error` clears next cycle.
- Robot feedback frozen at (2,2), target (5,2) -> E issued for 3 cycles; `error`=1 after STALL_LIMIT=3 unchanged steps; `move`=0 in ERR.
- From (4,4), target (1,6) -> W×3 then N×2. New target (0,0) offered mid-move -> `tgt_ready`=0 and the offer is ignored until DONE.
- Reset pulse during MOVE_Y -> `move`=0 immediately; IDLE and `steps`=0 after release. Target equal to the current position -> `arrived` at accept+3 with `steps`=0.
